dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, default 12, dmem word-address width.
REQ-002 Parameter DW, default 32, dmem data width.
REQ-003 clock  in  1  single block clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 p_req  in  1  processor access request; held with p_addr/p_data/p_wren until p_gnt.
REQ-006 p_wren  in  1  processor write (1) / read (0).
REQ-007 p_addr  in  AW  processor word address.
REQ-008 p_data  in  DW  processor write data.
REQ-009 p_gnt  out  1  one-cycle pulse: processor request accepted and issued to dmem this cycle.
REQ-010 p_rvalid  out  1  one-cycle pulse: p_q holds processor read data.
REQ-011 p_q  out  DW  processor read data.
REQ-012 l_req, l_wren, l_addr, l_data, l_gnt, l_rvalid, l_q: loader/debug port, same directions, widths and meaning as REQ-005..011.
REQ-013 l_excl  in  1  loader-exclusive mode; while high, the processor is never granted.
REQ-014 address_dmem  out  AW  dmem address.
REQ-015 data  out  DW  dmem write data.
REQ-016 wren  out  1  dmem write enable.
REQ-017 q_dmem  in  DW  dmem read data, valid one clock after the access cycle.

Function
REQ-018 Arbitration cycle N: candidates are p_req (masked by l_excl or p_gnt high) and l_req (masked by l_gnt high); the winner is registered.
REQ-019 Access cycle N+1: winner's gnt=1; address_dmem/data/wren driven from registers holding the winner's fields.
REQ-020 Non-granted cycles: wren=0; address_dmem and data hold their last values.
REQ-021 Both candidates valid: round-robin pointer selects; after each grant, pointer moves to the other requester.
REQ-022 Single candidate: granted regardless of pointer; pointer still updates.
REQ-023 Requester whose gnt is high in cycle N is not a candidate in cycle N; max one grant per requester per two cycles, aggregate throughput one access per cycle.
REQ-024 Read issued in cycle N+1: the owner's rvalid=1 in cycle N+2, its q equal to q_dmem; the other rvalid=0.
REQ-025 Writes produce no rvalid; gnt is the only completion indication.
REQ-026 p_q and l_q both equal q_dmem; content is defined only while the matching rvalid=1.
REQ-027 l_excl rising while a processor access is granted or its read is outstanding: that access and read complete normally.
REQ-028 gnt and rvalid never high for both ports in the same cycle.

Reset
REQ-029 While reset=1 at a clock edge: p_gnt, l_gnt, p_rvalid, l_rvalid, wren=0; address_dmem=0; data=0; pointer=processor.
REQ-030 Reset during an outstanding read: the pending rvalid is discarded and never asserted.
REQ-031 First arbitration occurs in the first cycle after reset deasserts.

Structure
REQ-032 Shared package dmem_arb_pkg SHALL hold AW/DW defaults and the requester-id encoding (REQ_PROC=0, REQ_LOAD=1).
REQ-033 Round-robin selection and pointer SHALL be one sub-module rr_arb2 (two requests in, one-hot grant out, pointer update on accept).
REQ-034 Read tracking SHALL be a one-entry owner/valid register; no other queuing.

Verification
REQ-035 Processor reads address 0x010, dmem preloaded 0xDEADBEEF -> p_gnt in cycle 1, address_dmem=0x010, wren=0, p_rvalid with p_q=0xDEADBEEF in cycle 2.
REQ-036 Both ports request continuously from reset -> grants alternate P,L,P,L one per cycle; no cycle with two grants.
REQ-037 Loader writes 0x0000_1234 to 0x0FF with l_excl=1, processor requesting -> only l_gnt, wren=1 in access cycle; processor read of 0x0FF after l_excl=0 returns 0x0000_1234.
REQ-038 Processor read granted, reset asserted in the following cycle -> p_rvalid stays 0; all outputs at REQ-029 values.
REQ-039 Loader write then processor read of the same address in back-to-back cycles -> p_q returns the newly written value.
REQ-040 Random mix of requests, 10000 cycles, vs. scoreboard memory model -> every read matches; every request granted within 2 cycles when l_excl=0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the dmem arbiter: default bus widths and requester ids.
package dmem_arb_pkg;

    localparam int AW_DEF = 12;
    localparam int DW_DEF = 32;

    // The bit position in the request/grant vectors equals the id value.
    typedef enum logic {
        REQ_PROC = 1'b0,
        REQ_LOAD = 1'b1
    } req_id_e;

    function automatic req_id_e other_req(input req_id_e id);
        return (id == REQ_PROC) ? REQ_LOAD : REQ_PROC;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin selector; the pointer names the requester that wins a tie.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    req_id_e ptr;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (ptr == REQ_PROC) ? 2'b01 : 2'b10;
        end
    end

    // Pointer always moves away from whoever just won, even without contention.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= REQ_PROC;
        end else if (accept) begin
            ptr <= other_req(gnt[1] ? REQ_LOAD : REQ_PROC);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port dmem between the processor and the loader/debug port.
// Arbitration in cycle N, registered access (gnt pulse) in N+1, read data in N+2.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          p_req,
    input  logic          p_wren,
    input  logic [AW-1:0] p_addr,
    input  logic [DW-1:0] p_data,
    output logic          p_gnt,
    output logic          p_rvalid,
    output logic [DW-1:0] p_q,
    input  logic          l_req,
    input  logic          l_wren,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_data,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic [DW-1:0] l_q,
    input  logic          l_excl,
    output logic [AW-1:0] address_dmem,
    output logic [DW-1:0] data,
    output logic          wren,
    input  logic [DW-1:0] q_dmem
);

    // Handshake: a requester holds req and its fields stable until it sees its
    // gnt pulse; gnt means the access is on the dmem bus in that very cycle.
    // A port whose gnt is high is not a candidate, so a held req is never
    // granted twice.
    logic       p_cand;
    logic       l_cand;
    logic [1:0] arb_gnt;

    logic       rd_valid;
    req_id_e    rd_owner;

    assign p_cand = p_req & ~l_excl & ~p_gnt;
    assign l_cand = l_req & ~l_gnt;

    rr_arb2 u_rr (
        .clock  (clock),
        .reset  (reset),
        .req    ({l_cand, p_cand}),
        .accept (|arb_gnt),
        .gnt    (arb_gnt)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            p_gnt        <= 1'b0;
            l_gnt        <= 1'b0;
            wren         <= 1'b0;
            address_dmem <= '0;
            data         <= '0;
        end else begin
            p_gnt <= arb_gnt[REQ_PROC];
            l_gnt <= arb_gnt[REQ_LOAD];
            if (arb_gnt[REQ_PROC]) begin
                address_dmem <= p_addr;
                data         <= p_data;
                wren         <= p_wren;
            end else if (arb_gnt[REQ_LOAD]) begin
                address_dmem <= l_addr;
                data         <= l_data;
                wren         <= l_wren;
            end else begin
                wren <= 1'b0;
            end
        end
    end

    // One outstanding read at most: dmem answers exactly one cycle later.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_owner <= REQ_PROC;
        end else begin
            rd_valid <= (p_gnt | l_gnt) & ~wren;
            rd_owner <= l_gnt ? REQ_LOAD : REQ_PROC;
        end
    end

    assign p_rvalid = rd_valid & (rd_owner == REQ_PROC);
    assign l_rvalid = rd_valid & (rd_owner == REQ_LOAD);
    assign p_q      = q_dmem;
    assign l_q      = q_dmem;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a long random mix, checked
// against a memory/arbitration reference model and per-port expected queues.
module tb_dmem_arbiter;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          p_req = 1'b0, p_wren = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [DW-1:0] p_data = '0;
  logic          l_req = 1'b0, l_wren = 1'b0;
  logic [AW-1:0] l_addr = '0;
  logic [DW-1:0] l_data = '0;
  logic          l_excl = 1'b0;
  logic          p_gnt, p_rvalid, l_gnt, l_rvalid, wren;
  logic [DW-1:0] p_q, l_q, data, q_dmem;
  logic [AW-1:0] address_dmem;

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clock(clock), .reset(reset),
    .p_req(p_req), .p_wren(p_wren), .p_addr(p_addr), .p_data(p_data),
    .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_q(p_q),
    .l_req(l_req), .l_wren(l_wren), .l_addr(l_addr), .l_data(l_data),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_q(l_q),
    .l_excl(l_excl),
    .address_dmem(address_dmem), .data(data), .wren(wren), .q_dmem(q_dmem)
  );

  // dmem: synchronous single-port RAM, read data one clock after the access
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clock) begin
    if (wren) mem[address_dmem] <= data;
    q_dmem <= mem[address_dmem];
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] p_exp_q[$];
  logic [DW-1:0] l_exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the access on the bus in the current cycle and what follows.
  logic          e_pg = 1'b0, e_lg = 1'b0, e_prv = 1'b0, e_lrv = 1'b0, e_wren = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_data = '0;
  logic          last_was_l = 1'b1;
  int            p_wait = 0, l_wait = 0;
  logic          p_wait_ok = 1'b0, l_wait_ok = 1'b0;

  always @(negedge clock) begin : monitor
    logic pc, lc, wp, wl;
    check("outputs", 64'({p_gnt, l_gnt, p_rvalid, l_rvalid, wren, address_dmem, data}),
          64'({e_pg, e_lg, e_prv, e_lrv, e_wren, e_addr, e_data}));
    if (p_rvalid === 1'b1) begin
      if (p_exp_q.size() == 0) check("p_rvalid_unexpected", 64'(1), 64'(0));
      else check("p_q", 64'(p_q), 64'(p_exp_q.pop_front()));
    end
    if (l_rvalid === 1'b1) begin
      if (l_exp_q.size() == 0) check("l_rvalid_unexpected", 64'(1), 64'(0));
      else check("l_q", 64'(l_q), 64'(l_exp_q.pop_front()));
    end

    // Latency bound only applies to waits free of reset and l_excl.
    if (p_gnt === 1'b1) begin
      if (p_wait_ok) check("p_latency", 64'(p_wait), 64'(p_wait <= 2 ? p_wait : 2));
      p_wait = 0; p_wait_ok = 1'b1;
    end else if (p_req) p_wait++;
    if (l_gnt === 1'b1) begin
      if (l_wait_ok) check("l_latency", 64'(l_wait), 64'(l_wait <= 2 ? l_wait : 2));
      l_wait = 0; l_wait_ok = 1'b1;
    end else if (l_req) l_wait++;
    if (reset || l_excl) p_wait_ok = 1'b0;
    if (reset) l_wait_ok = 1'b0;

    // Memory effect of the access happening now.
    if (e_pg | e_lg) begin
      if (e_wren) ref_mem[e_addr] = e_data;
      else if (e_pg) p_exp_q.push_back(ref_mem[e_addr]);
      else l_exp_q.push_back(ref_mem[e_addr]);
    end

    if (reset) begin
      {e_pg, e_lg, e_prv, e_lrv, e_wren} = '0;
      e_addr = '0; e_data = '0; last_was_l = 1'b1;
      p_exp_q.delete(); l_exp_q.delete();
    end else begin
      e_prv = e_pg & ~e_wren;
      e_lrv = e_lg & ~e_wren;
      pc = p_req & ~l_excl & ~e_pg;
      lc = l_req & ~e_lg;
      wp = pc & (~lc | last_was_l);
      wl = lc & ~wp;
      e_pg = wp; e_lg = wl;
      if (wp) begin
        e_wren = p_wren; e_addr = p_addr; e_data = p_data; last_was_l = 1'b0;
      end else if (wl) begin
        e_wren = l_wren; e_addr = l_addr; e_data = l_data; last_was_l = 1'b1;
      end else e_wren = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic drive(input bit port, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (port) begin l_req = 1'b1; l_wren = w; l_addr = a; l_data = d; end
    else      begin p_req = 1'b1; p_wren = w; p_addr = a; p_data = d; end
  endtask

  task automatic wait_gnt(input bit port);
    bit got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if ((port ? l_gnt : p_gnt) === 1'b1) begin got = 1'b1; break; end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL gnt_timeout port=%0d: got no grant, expected one within 8 cycles", port);
    end
    tick();
    if (port) l_req = 1'b0; else p_req = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    logic pg, lg;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[12'h010] = 32'hDEADBEEF;
    ref_mem[12'h010] = 32'hDEADBEEF;
    repeat (3) tick();

    // single processor read
    reset = 1'b0;
    drive(0, 0, 12'h010, '0);
    wait_gnt(0);
    repeat (3) tick();

    // both ports requesting continuously
    drive(0, 0, 12'h005, '0);
    drive(1, 0, 12'h006, '0);
    repeat (8) tick();
    p_req = 1'b0; l_req = 1'b0;
    repeat (3) tick();

    // loader write under l_excl, processor kept waiting, then reads it back
    l_excl = 1'b1;
    drive(0, 0, 12'h0FF, '0);
    drive(1, 1, 12'h0FF, 32'h0000_1234);
    wait_gnt(1);
    repeat (3) tick();
    l_excl = 1'b0;
    wait_gnt(0);
    repeat (3) tick();

    // loader write then processor read of the same address, back to back
    drive(1, 1, 12'h020, 32'hCAFE_0001);
    tick();
    drive(0, 0, 12'h020, '0);
    tick();
    l_req = 1'b0;
    wait_gnt(0);
    repeat (3) tick();

    // reset while a processor read is in flight
    drive(0, 0, 12'h010, '0);
    tick();
    reset = 1'b1; p_req = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();

    // random mix
    for (int c = 0; c < 10000; c++) begin
      @(negedge clock);
      pg = p_gnt; lg = l_gnt;
      tick();
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 999) < 2) reset = 1'b1;
      if ($urandom_range(0, 99) < 3) l_excl = ~l_excl;
      if (!p_req || pg) begin
        if ($urandom_range(0, 99) < 60)
          drive(0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom);
        else p_req = 1'b0;
      end
      if (!l_req || lg) begin
        if ($urandom_range(0, 99) < 60)
          drive(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom);
        else l_req = 1'b0;
      end
    end

    reset = 1'b0; l_excl = 1'b0; p_req = 1'b0; l_req = 1'b0;
    repeat (5) tick();
    check("p_queue_drained", 64'(p_exp_q.size()), 64'(0));
    check("l_queue_drained", 64'(l_exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
